sdrc_app_resp: RTL and testbench



---
 rtl/sdrc_app_resp.sv | 154 +++++++++++++++
 tb/tb_sdrc_app_resp.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdrc_app_resp.sv
// SDRAM-controller application-side responder: handles burst requests against an internal word memory.
// Define SDRC_APP_RESP_STALL_EN to add one idle cycle before every 4th beat of a burst.
module sdrc_app_resp #(
  parameter int DW      = 32,
  parameter int MEM_AW  = 8,
  parameter int ACK_DLY = 2,
  parameter int RD_LAT  = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            app_req,
  input  logic [29:0]     app_req_addr,
  input  logic [8:0]      app_req_len,
  input  logic            app_req_wr_n,
  output logic            app_req_ack,
  input  logic [DW-1:0]   app_wr_data,
  input  logic [DW/8-1:0] app_wr_en_n,
  output logic            app_wr_next_req,
  output logic            app_rd_valid,
  output logic [DW-1:0]   app_rd_data,
  output logic            busy_n
);

  // state  | meaning
  // IDLE   | waiting for app_req
  // WAIT   | ACK_DLY-cycle delay before accept; abandoned if app_req drops
  // ACK    | app_req_ack pulse, dispatch by direction / zero length
  // WRITE  | one write beat per app_wr_next_req
  // RDLAT  | read latency countdown
  // READ   | one read beat per app_rd_valid
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_ACK, S_WRITE, S_RDLAT, S_READ
  } state_t;

  localparam logic [7:0] ACK_LD = 8'(ACK_DLY - 1);
  localparam logic [7:0] RD_LD  = 8'(RD_LAT - 2);

  state_t            state_q, state_d;
  logic [7:0]        tmr_q, tmr_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [8:0]        len_q, len_d;
  logic [8:0]        beat_q, beat_d;
  logic              wr_n_q, wr_n_d;
  logic              beat_go;
  logic              beat_fire;
  logic              addr_unused;

  logic [DW-1:0] mem [0:(1<<MEM_AW)-1];

  assign addr_unused = ^app_req_addr[29:MEM_AW];

`ifdef SDRC_APP_RESP_STALL_EN
  logic gap_q;

  // gap_q marks that the stall before a 4th beat has already been taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) gap_q <= 1'b0;
    else       gap_q <= ((state_q == S_WRITE) || (state_q == S_READ)) && !beat_go;
  end

  assign beat_go = !((beat_q[1:0] == 2'b11) && !gap_q);
`else
  assign beat_go = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      wr_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      wr_n_q  <= wr_n_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    tmr_d           = tmr_q;
    addr_d          = addr_q;
    len_d           = len_q;
    beat_d          = beat_q;
    wr_n_d          = wr_n_q;
    app_req_ack     = 1'b0;
    app_wr_next_req = 1'b0;
    app_rd_valid    = 1'b0;
    beat_fire       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (app_req) begin
          addr_d = app_req_addr[MEM_AW-1:0];
          len_d  = app_req_len;
          wr_n_d = app_req_wr_n;
          beat_d = '0;
          tmr_d  = ACK_LD;
          state_d = (ACK_DLY == 0) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!app_req)          state_d = S_IDLE;
        else if (tmr_q == '0)  state_d = S_ACK;
        else                   tmr_d = tmr_q - 8'd1;
      end
      S_ACK: begin
        app_req_ack = 1'b1;
        tmr_d = RD_LD;
        if (len_q == '0)       state_d = S_IDLE;
        else if (!wr_n_q)      state_d = S_WRITE;
        else if (RD_LAT <= 1)  state_d = S_READ;
        else                   state_d = S_RDLAT;
      end
      S_WRITE: begin
        app_wr_next_req = beat_go;
        beat_fire       = beat_go;
      end
      S_RDLAT: begin
        if (tmr_q == '0) state_d = S_READ;
        else             tmr_d = tmr_q - 8'd1;
      end
      S_READ: begin
        app_rd_valid = beat_go;
        beat_fire    = beat_go;
      end
      default: state_d = S_IDLE;
    endcase

    if (beat_fire) begin
      addr_d = addr_q + 1'b1;
      beat_d = beat_q + 9'd1;
      if (beat_q == len_q - 9'd1) state_d = S_IDLE;
    end
  end

  // memory is intentionally left out of reset so completed beats survive it
  always_ff @(posedge clk) begin
    if (app_wr_next_req) begin
      for (int i = 0; i < DW/8; i++) begin
        if (!app_wr_en_n[i]) mem[addr_q][8*i +: 8] <= app_wr_data[8*i +: 8];
      end
    end
  end

  assign app_rd_data = app_rd_valid ? mem[addr_q] : '0;
  assign busy_n      = (state_q == S_IDLE);

endmodule

// File: tb/tb_sdrc_app_resp.sv
// Directed self-checking bench for sdrc_app_resp (default parameters).
// Beat timing expectations also cover the SDRC_APP_RESP_STALL_EN build.
module tb_sdrc_app_resp;

  localparam int ACK_DLY = 2;
  localparam int RD_LAT  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        app_req;
  logic [29:0] app_req_addr;
  logic [8:0]  app_req_len;
  logic        app_req_wr_n;
  logic        app_req_ack;
  logic [31:0] app_wr_data;
  logic [3:0]  app_wr_en_n;
  logic        app_wr_next_req;
  logic        app_rd_valid;
  logic [31:0] app_rd_data;
  logic        busy_n;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] wq [0:15];
  logic [31:0] rq [0:15];
  int nbeats;

  sdrc_app_resp dut (
    .clk(clk), .reset(reset), .app_req(app_req), .app_req_addr(app_req_addr),
    .app_req_len(app_req_len), .app_req_wr_n(app_req_wr_n), .app_req_ack(app_req_ack),
    .app_wr_data(app_wr_data), .app_wr_en_n(app_wr_en_n), .app_wr_next_req(app_wr_next_req),
    .app_rd_valid(app_rd_valid), .app_rd_data(app_rd_data), .busy_n(busy_n)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Beat b lands i cycles after the ACK cycle when i == lead + b (+ one per stall taken).
  function automatic bit exp_bit(int lead, int len, int i);
    int pos;
    for (int b = 0; b < len; b++) begin
      pos = lead + b;
`ifdef SDRC_APP_RESP_STALL_EN
      pos = pos + (b + 1) / 4;
`endif
      if (pos == i) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic run_burst(input string tag, input bit wr_n, input logic [29:0] addr,
                           input int len);
    int lat, lead, span, bad;
    logic sig, other;
    app_req      = 1'b1;
    app_req_addr = addr;
    app_req_len  = 9'(len);
    app_req_wr_n = wr_n;
    tick();
    chk({tag, ":busy"}, {31'd0, busy_n}, 32'd0);
    lat = 0;
    while (app_req_ack !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, ":ack_lat"}, 32'(lat), 32'(ACK_DLY));
    app_req = 1'b0;
    lead = wr_n ? RD_LAT : 1;
    span = lead + len + len / 4 + 3;
    nbeats = 0;
    bad = 0;
    for (int i = 1; i <= span; i++) begin
      tick();
      sig   = wr_n ? app_rd_valid : app_wr_next_req;
      other = wr_n ? app_wr_next_req : app_rd_valid;
      if (sig !== exp_bit(lead, len, i)) bad++;
      if (other !== 1'b0 || app_req_ack !== 1'b0) bad++;
      if (sig === 1'b1) begin
        if (wr_n) begin
          if (nbeats < 16) rq[nbeats] = app_rd_data;
        end else begin
          app_wr_data = (nbeats < 16) ? wq[nbeats] : (32'h5A00_0000 | 32'(nbeats));
        end
        nbeats++;
      end
    end
    chk({tag, ":beats"}, 32'(nbeats), 32'(len));
    chk({tag, ":timing_bad"}, 32'(bad), 32'd0);
    chk({tag, ":idle"}, {31'd0, busy_n}, 32'd1);
  endtask

  initial begin
    int lat, k;
    reset = 1'b1;
    app_req = 1'b0;
    app_req_addr = '0;
    app_req_len = '0;
    app_req_wr_n = 1'b1;
    app_wr_data = '0;
    app_wr_en_n = '0;
    tick();
    tick();
    chk("rst:ack", {31'd0, app_req_ack}, 32'd0);
    chk("rst:next_req", {31'd0, app_wr_next_req}, 32'd0);
    chk("rst:rd_valid", {31'd0, app_rd_valid}, 32'd0);
    chk("rst:rd_data", app_rd_data, 32'd0);
    chk("rst:busy_n", {31'd0, busy_n}, 32'd1);
    reset = 1'b0;

    // 5-beat write and read-back at 0x10
    wq[0] = 32'h11223344; wq[1] = 32'h22334455; wq[2] = 32'h33445566;
    wq[3] = 32'h44556677; wq[4] = 32'h55667788;
    run_burst("wr10", 1'b0, 30'h10, 5);
    run_burst("rd10", 1'b1, 30'h10, 5);
    chk("rd10:d0", rq[0], 32'h11223344);
    chk("rd10:d1", rq[1], 32'h22334455);
    chk("rd10:d2", rq[2], 32'h33445566);
    chk("rd10:d3", rq[3], 32'h44556677);
    chk("rd10:d4", rq[4], 32'h55667788);

    // byte-enable merge
    wq[0] = 32'hAABBCCDD;
    run_burst("wr20a", 1'b0, 30'h20, 1);
    wq[0] = 32'h11223344;
    app_wr_en_n = 4'b1110;
    run_burst("wr20b", 1'b0, 30'h20, 1);
    app_wr_en_n = 4'b0000;
    run_burst("rd20", 1'b1, 30'h20, 1);
    chk("rd20:merge", rq[0], 32'hAABBCC44);

    // address wrap at top of memory
    wq[0] = 32'd1; wq[1] = 32'd2; wq[2] = 32'd3; wq[3] = 32'd4;
    run_burst("wrFE", 1'b0, 30'hFE, 4);
    run_burst("rdFE", 1'b1, 30'hFE, 4);
    chk("rdFE:d0", rq[0], 32'd1);
    chk("rdFE:d1", rq[1], 32'd2);
    chk("rdFE:d2", rq[2], 32'd3);
    chk("rdFE:d3", rq[3], 32'd4);
    run_burst("rd00", 1'b1, 30'h00, 1);
    chk("rd00:d", rq[0], 32'd3);

    // request withdrawn after one WAIT cycle
    app_req = 1'b1; app_req_addr = 30'h10; app_req_len = 9'd1; app_req_wr_n = 1'b0;
    app_wr_data = 32'hDEADBEEF;
    tick();
    chk("drop:busy", {31'd0, busy_n}, 32'd0);
    app_req = 1'b0;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (app_req_ack !== 1'b0 || app_wr_next_req !== 1'b0 || app_rd_valid !== 1'b0) k++;
    end
    chk("drop:no_activity", 32'(k), 32'd0);
    chk("drop:idle", {31'd0, busy_n}, 32'd1);
    run_burst("rd10b", 1'b1, 30'h10, 1);
    chk("drop:mem_kept", rq[0], 32'h11223344);

    // zero-length request: ack then straight back to idle
    run_burst("len0", 1'b1, 30'h10, 0);

    // reset mid-burst: beats 0-2 persist, 3-4 keep old contents
    wq[0] = 32'hA0; wq[1] = 32'hA1; wq[2] = 32'hA2; wq[3] = 32'hA3; wq[4] = 32'hA4;
    run_burst("wr40old", 1'b0, 30'h40, 5);
    wq[0] = 32'hB0; wq[1] = 32'hB1; wq[2] = 32'hB2; wq[3] = 32'hB3; wq[4] = 32'hB4;
    app_req = 1'b1; app_req_addr = 30'h40; app_req_len = 9'd5; app_req_wr_n = 1'b0;
    tick();
    lat = 0;
    while (app_req_ack !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk("rstb:ack_lat", 32'(lat), 32'(ACK_DLY));
    app_req = 1'b0;
    k = 0;
    lat = 0;
    while (k < 3 && lat < 20) begin
      tick();
      lat++;
      if (app_wr_next_req === 1'b1) begin
        app_wr_data = wq[k];
        k++;
      end
    end
    chk("rstb:three_beats", 32'(k), 32'd3);
    tick();
`ifndef SDRC_APP_RESP_STALL_EN
    chk("rstb:beat3_pending", {31'd0, app_wr_next_req}, 32'd1);
`endif
    app_wr_data = wq[3];
    reset = 1'b1;
    #1;
    chk("rstb:next_req", {31'd0, app_wr_next_req}, 32'd0);
    chk("rstb:ack", {31'd0, app_req_ack}, 32'd0);
    chk("rstb:rd_valid", {31'd0, app_rd_valid}, 32'd0);
    chk("rstb:rd_data", app_rd_data, 32'd0);
    chk("rstb:busy_n", {31'd0, busy_n}, 32'd1);
    #1;
    reset = 1'b0;
    run_burst("rd40", 1'b1, 30'h40, 5);
    chk("rd40:d0", rq[0], 32'hB0);
    chk("rd40:d1", rq[1], 32'hB1);
    chk("rd40:d2", rq[2], 32'hB2);
    chk("rd40:d3", rq[3], 32'hA3);
    chk("rd40:d4", rq[4], 32'hA4);

    // maximum length burst: exactly 511 beats, wrapping through all of memory
    run_burst("wr511", 1'b0, 30'h80, 511);
    run_burst("rd7E", 1'b1, 30'h7E, 2);
    chk("wr511:last", rq[0], 32'h5A0001FE);
    chk("wr511:no_extra", rq[1], 32'h5A0000FF);

    // 8-beat read covers the stall gaps when that feature is built in
    run_burst("rd8", 1'b1, 30'h00, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
